// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, purely combinational 4-bit ALU.
// Exactly one operation is in flight at a time: IDLE accepts, EXEC evaluates, RESP holds the result.
module alu_arbiter (
`ifdef USE_POWER_PINS
  inout  wire        vccd1,
  inout  wire        vssd1,
`endif
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req0_op,
  input  logic [1:0] req1_op,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  input  logic       rsp0_ready,
  input  logic       rsp1_ready,
  output logic [3:0] rsp_c,
  output logic       rsp_ovf,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_ctrl0,
  output logic       alu_ctrl1,
  input  logic [3:0] alu_c,
  input  logic       alu_ovf,
  output logic       busy,
  output logic       grant_id,
  output logic [7:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     r_state;
  logic       r_last;
  logic       r_grant;
  logic [3:0] r_aluA;
  logic [3:0] r_aluB;
  logic [1:0] r_aluOp;
  logic [3:0] r_rspC;
  logic       r_rspOvf;
  logic [7:0] r_opsDone;

  logic w_any;
  logic w_winner;
  logic w_accept;
  logic w_rspReady;

  // On a tie the requester that did not win last time gets the ALU.
  assign w_any      = req0_valid | req1_valid;
  assign w_winner   = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_accept   = (r_state == IDLE) && w_any && !wb_rst_i;
  assign w_rspReady = r_grant ? rsp1_ready : rsp0_ready;

  assign req0_ready = w_accept && !w_winner;
  assign req1_ready = w_accept &&  w_winner;
  assign rsp0_valid = (r_state == RESP) && !r_grant;
  assign rsp1_valid = (r_state == RESP) &&  r_grant;
  assign busy       = (r_state != IDLE);
  assign grant_id   = r_grant;
  assign rsp_c      = r_rspC;
  assign rsp_ovf    = r_rspOvf;
  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_ctrl0  = r_aluOp[0];
  assign alu_ctrl1  = r_aluOp[1];
  assign ops_done   = r_opsDone;

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_aluA    <= 4'd0;
      r_aluB    <= 4'd0;
      r_aluOp   <= 2'd0;
      r_rspC    <= 4'd0;
      r_rspOvf  <= 1'b0;
      r_opsDone <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_aluA  <= w_winner ? req1_a  : req0_a;
            r_aluB  <= w_winner ? req1_b  : req0_b;
            r_aluOp <= w_winner ? req1_op : req0_op;
            r_grant <= w_winner;
            r_last  <= w_winner;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rspC   <= alu_c;
          r_rspOvf <= alu_ovf;
          r_state  <= RESP;
        end
        RESP: begin
          if (w_rspReady) begin
            r_opsDone <= r_opsDone + 8'd1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
